// File: rtl/traffic_phase_scheduler_if.sv
// rtl/traffic_phase_scheduler_if.sv - request inputs and lamp/status outputs of the phase scheduler
interface traffic_phase_scheduler_if;
  logic       side_req;
  logic       ped_req;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;
  logic [2:0] phase;
  logic       side_pending;
  logic       ped_pending;

  // Board side: drives the requests, observes lamps and status
  modport master (
    output side_req,
    output ped_req,
    input  main_light,
    input  side_light,
    input  walk,
    input  phase,
    input  side_pending,
    input  ped_pending
  );

  // Scheduler side
  modport slave (
    input  side_req,
    input  ped_req,
    output main_light,
    output side_light,
    output walk,
    output phase,
    output side_pending,
    output ped_pending
  );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - intersection phase sequencer with latched requests and round-robin side/ped service
module traffic_phase_scheduler #(
  parameter int unsigned TICK_DIV      = 25000000,
  parameter int unsigned MIN_MAIN_TIME = 6,
  parameter int unsigned SIDE_GO_TIME  = 6,
  parameter int unsigned WAIT_TIME     = 3,
  parameter int unsigned RED_TIME      = 1,
  parameter int unsigned PED_TIME      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  traffic_phase_scheduler_if.slave  bus
);

  localparam logic [2:0] S_MAIN_GO   = 3'd0;
  localparam logic [2:0] S_MAIN_WAIT = 3'd1;
  localparam logic [2:0] S_ALL_RED   = 3'd2;
  localparam logic [2:0] S_SIDE_GO   = 3'd3;
  localparam logic [2:0] S_SIDE_WAIT = 3'd4;
  localparam logic [2:0] S_PED_WALK  = 3'd5;

  localparam logic TGT_SIDE = 1'b0;
  localparam logic TGT_PED  = 1'b1;

  localparam int unsigned MAX_A = (SIDE_GO_TIME > WAIT_TIME) ? SIDE_GO_TIME : WAIT_TIME;
  localparam int unsigned MAX_B = (RED_TIME > PED_TIME) ? RED_TIME : PED_TIME;
  localparam int unsigned MAXD  = (MAX_A > MAX_B) ? MAX_A : MAX_B;

  localparam int PW = $clog2(TICK_DIV);
  localparam int TW = $clog2(MAXD + 1);
  localparam int EW = $clog2(MIN_MAIN_TIME + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [EW-1:0] MIN_MAIN   = EW'(MIN_MAIN_TIME);
  localparam logic [TW-1:0] D_SIDE_GO  = TW'(SIDE_GO_TIME);
  localparam logic [TW-1:0] D_WAIT     = TW'(WAIT_TIME);
  localparam logic [TW-1:0] D_RED      = TW'(RED_TIME);
  localparam logic [TW-1:0] D_PED      = TW'(PED_TIME);

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [EW-1:0] elapsed_q, elapsed_d;
  logic          side_pending_q, side_pending_d;
  logic          ped_pending_q, ped_pending_d;
  logic          target_q, target_d;
  logic          last_served_q, last_served_d;
  logic          returning_q, returning_d;

  logic          tick;
  logic [TW-1:0] dur;
  logic [TW-1:0] timer_inc;
  logic [EW-1:0] elapsed_inc;
  logic          timer_done;
  logic          state_change;
  logic          enter_side;
  logic          enter_ped;

  // Tick strobe and the duration of the current timed state
  always_comb begin
    tick        = (presc_q == PRESC_LAST);
    timer_inc   = timer_q + 1'b1;
    elapsed_inc = (elapsed_q == MIN_MAIN) ? MIN_MAIN : elapsed_q + 1'b1;
    dur         = D_RED;
    case (state_q)
      S_MAIN_WAIT: dur = D_WAIT;
      S_SIDE_GO:   dur = D_SIDE_GO;
      S_SIDE_WAIT: dur = D_WAIT;
      S_PED_WALK:  dur = D_PED;
      default:     dur = D_RED;
    endcase
    timer_done = tick && (timer_inc == dur);
  end

  // Phase sequencing, arbitration at main yield, and bookkeeping registers
  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    last_served_d = last_served_q;
    returning_d   = returning_q;

    case (state_q)
      S_MAIN_GO: begin
        if (tick && (elapsed_inc == MIN_MAIN) && (side_pending_q || ped_pending_q)) begin
          state_d = S_MAIN_WAIT;
          if (side_pending_q && ped_pending_q) begin
            target_d = (last_served_q == TGT_PED) ? TGT_SIDE : TGT_PED;
          end else begin
            target_d = side_pending_q ? TGT_SIDE : TGT_PED;
          end
        end
      end
      S_MAIN_WAIT: if (timer_done) state_d = S_ALL_RED;
      S_ALL_RED: begin
        if (timer_done) begin
          if (returning_q)               state_d = S_MAIN_GO;
          else if (target_q == TGT_SIDE) state_d = S_SIDE_GO;
          else                           state_d = S_PED_WALK;
        end
      end
      S_SIDE_GO:   if (timer_done) state_d = S_SIDE_WAIT;
      S_SIDE_WAIT: if (timer_done) state_d = S_ALL_RED;
      S_PED_WALK:  if (timer_done) state_d = S_ALL_RED;
      default:     state_d = S_MAIN_GO;
    endcase

    state_change = (state_d != state_q);
    enter_side   = state_change && (state_d == S_SIDE_GO);
    enter_ped    = state_change && (state_d == S_PED_WALK);

    // The ALL_RED after a service phase must lead home to main green
    if (enter_side || enter_ped) begin
      returning_d = 1'b1;
    end else if (state_change && (state_d == S_MAIN_GO)) begin
      returning_d = 1'b0;
    end

    if (enter_side)     last_served_d = TGT_SIDE;
    else if (enter_ped) last_served_d = TGT_PED;

    presc_d = (state_change || tick) ? '0 : presc_q + 1'b1;

    // Timer only runs in timed states, so it can never wrap while main idles
    if (state_change)                        timer_d = '0;
    else if (tick && state_q != S_MAIN_GO)   timer_d = timer_inc;
    else                                     timer_d = timer_q;

    if (state_change)                        elapsed_d = '0;
    else if (tick && state_q == S_MAIN_GO)   elapsed_d = elapsed_inc;
    else                                     elapsed_d = elapsed_q;

    // Serving clears the latch and wins over a request in the same cycle
    if (enter_side)
      side_pending_d = 1'b0;
    else if (bus.side_req && state_q != S_SIDE_GO && state_q != S_SIDE_WAIT)
      side_pending_d = 1'b1;
    else
      side_pending_d = side_pending_q;

    if (enter_ped)
      ped_pending_d = 1'b0;
    else if (bus.ped_req && state_q != S_PED_WALK)
      ped_pending_d = 1'b1;
    else
      ped_pending_d = ped_pending_q;
  end

  // State registers with synchronous reset; side wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_MAIN_GO;
      presc_q        <= '0;
      timer_q        <= '0;
      elapsed_q      <= '0;
      side_pending_q <= 1'b0;
      ped_pending_q  <= 1'b0;
      target_q       <= TGT_SIDE;
      last_served_q  <= TGT_PED;
      returning_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      timer_q        <= timer_d;
      elapsed_q      <= elapsed_d;
      side_pending_q <= side_pending_d;
      ped_pending_q  <= ped_pending_d;
      target_q       <= target_d;
      last_served_q  <= last_served_d;
      returning_q    <= returning_d;
    end
  end

  // Lamp and status decode from registered state only
  always_comb begin
    bus.main_light   = 3'b100;
    bus.side_light   = 3'b100;
    bus.walk         = 1'b0;
    bus.phase        = state_q;
    bus.side_pending = side_pending_q;
    bus.ped_pending  = ped_pending_q;
    case (state_q)
      S_MAIN_GO:   bus.main_light = 3'b001;
      S_MAIN_WAIT: bus.main_light = 3'b010;
      S_SIDE_GO:   bus.side_light = 3'b001;
      S_SIDE_WAIT: bus.side_light = 3'b010;
      S_PED_WALK:  bus.walk       = 1'b1;
      default:     bus.walk       = 1'b0;
    endcase
  end

endmodule
